// File: rtl/multicycle_mem_responder.sv
// ============================================================================
// Module   : multicycle_mem_responder
// Brief    : Unified I/D memory with wait states, a MemReady pulse, address
//            error reporting and a sticky overrun flag. The optional
//            MEM_BYTE_ENABLE_EN build adds per-lane write enables (ByteEn).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        MemReq,
    input  logic        MemWrite,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
`ifdef MEM_BYTE_ENABLE_EN
    input  logic [3:0]  ByteEn,
`endif
    output logic [31:0] ReadData,
    output logic        MemReady,
    output logic        Busy,
    output logic        AddrErr,
    output logic        Overrun
);

    localparam int         AW          = $clog2(DEPTH_WORDS);
    localparam logic [3:0] C_WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_RESPOND = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            we_q, we_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [31:0]     wdata_q, wdata_d;
    logic            err_q, err_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            ovr_q, ovr_d;
    logic [3:0]      be_q, be_d;
    logic [3:0]      w_in_be;

    logic [31:0]     mem_q [DEPTH_WORDS];

    logic            w_in_err;
    logic [AW-1:0]   w_in_idx;

`ifdef MEM_BYTE_ENABLE_EN
    assign w_in_be = ByteEn;
`else
    assign w_in_be = 4'hF;
`endif

    // Misaligned or beyond the array: the access completes normally but is neutralised.
    assign w_in_err = (Addr[1:0] != 2'b00) || (|Addr[31:AW+2]);
    assign w_in_idx = Addr[AW+1:2];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        be_d    = be_q;
        rdata_d = rdata_q;
        ovr_d   = ovr_q;

        case (state_q)
            S_IDLE: begin
                if (MemReq) begin
                    we_d    = MemWrite;
                    idx_d   = w_in_idx;
                    wdata_d = WriteData;
                    err_d   = w_in_err;
                    be_d    = w_in_be;
                    if (WAIT_STATES > 0) begin
                        cnt_d   = C_WAIT_LOAD;
                        state_d = S_WAIT;
                    end else begin
                        state_d = S_RESPOND;
                        // Zero-wait reads must use the live request fields.
                        if (!MemWrite) begin
                            rdata_d = w_in_err ? 32'd0 : mem_q[w_in_idx];
                        end
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_RESPOND;
                    if (!we_q) begin
                        rdata_d = err_q ? 32'd0 : mem_q[idx_q];
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESPOND: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (MemReq && (state_q != S_IDLE)) begin
            ovr_d = 1'b1;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= 32'd0;
            err_q   <= 1'b0;
            be_q    <= 4'd0;
            rdata_q <= 32'd0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            be_q    <= be_d;
            rdata_q <= rdata_d;
            ovr_q   <= ovr_d;
        end
    end

    // Array is not reset; a reset forces IDLE so a pending write never lands.
    always_ff @(posedge Clk) begin
        if ((state_q == S_RESPOND) && we_q && !err_q) begin
            for (int i = 0; i < 4; i++) begin
                if (be_q[i]) begin
                    mem_q[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

    assign ReadData = rdata_q;
    assign MemReady = (state_q == S_RESPOND);
    assign Busy     = (state_q != S_IDLE);
    assign AddrErr  = (state_q == S_RESPOND) && err_q;
    assign Overrun  = ovr_q;

endmodule

`default_nettype wire
